fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32 core. Holds the program counter, drives the word address into the combinational instruction ROM, and registers the returned instruction into the IF/ID pipeline register. Handles hazard stalls, control-flow redirects from EX, and halt detection (HALT_INSTR).

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core-wide constants and types for the RV32 pipeline.
package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR       = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // What the fetch stage does this cycle, in priority order.
  typedef enum logic [1:0] {
    ACT_REDIRECT = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_HALTED   = 2'd2,
    ACT_FETCH    = 2'd3
  } fetch_action_e;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID pipeline register. Handles stalls, EX redirects and halt.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4,
  output logic [31:0]       id_instr,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  fetch_action_e action;

  logic [31:0]   pc_next;
  logic          halted_next;
  logic          id_valid_next;
  logic [31:0]   id_pc_next;
  logic [31:0]   id_pc_plus4_next;
  logic [31:0]   id_instr_next;
  logic [31:0]   fetch_count_next;

  // ROM index comes straight from the registered PC; fetch wraps around the ROM.
  assign imem_addr = pc[ADDR_W+1:2];
  assign pc_plus4  = pc + 32'd4;

  // Pick this cycle's action: redirect beats stall beats halted beats fetch.
  always_comb begin
    action = ACT_FETCH;
    if (redirect_valid) begin
      action = ACT_REDIRECT;
    end else if (stall) begin
      action = ACT_STALL;
    end else if (halted) begin
      action = ACT_HALTED;
    end
  end

  // Compute next PC, halt flag, IF/ID contents and counter for the chosen action.
  always_comb begin
    pc_next          = pc;
    halted_next      = halted;
    id_valid_next    = id_valid;
    id_pc_next       = id_pc;
    id_pc_plus4_next = id_pc_plus4;
    id_instr_next    = id_instr;
    fetch_count_next = fetch_count;
    unique case (action)
      ACT_REDIRECT: begin
        pc_next       = align_word(redirect_pc);
        halted_next   = 1'b0;
        id_valid_next = 1'b0;
        id_instr_next = NOP_INSTR;
      end
      ACT_STALL: begin
      end
      ACT_HALTED: begin
        id_valid_next = 1'b0;
        id_instr_next = NOP_INSTR;
      end
      ACT_FETCH: begin
        id_valid_next    = 1'b1;
        id_pc_next       = pc;
        id_pc_plus4_next = pc_plus4;
        id_instr_next    = imem_instr;
        fetch_count_next = fetch_count + 32'd1;
        if (imem_instr == HALT_INSTR) begin
          halted_next = 1'b1;
        end else begin
          pc_next = pc_plus4;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset wipes PC, halt, IF/ID and the counter immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      halted      <= 1'b0;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_instr    <= NOP_INSTR;
      fetch_count <= 32'd0;
    end else begin
      pc          <= pc_next;
      halted      <= halted_next;
      id_valid    <= id_valid_next;
      id_pc       <= id_pc_next;
      id_pc_plus4 <= id_pc_plus4_next;
      id_instr    <= id_instr_next;
      fetch_count <= fetch_count_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset
// sequence, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam int          ADDR_W = 5;
  localparam int          WORDS  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc_plus4;
  logic [31:0]       id_instr;
  logic              halted;
  logic [31:0]       fetch_count;

  logic [31:0] rom [0:WORDS-1];

  int vecCount  = 0;
  int missCount = 0;

  // Behavioural model state
  logic [31:0] mPc, mIdPc, mIdP4, mInstr, mCount;
  logic        mValid, mHalted;

  typedef struct {
    logic        stl;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] idpc;
    logic [31:0] idp4;
    logic [31:0] instr;
    logic        hlt;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs [18];

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  assign imem_instr = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] addr, input logic valid,
                          input logic [31:0] idpc, input logic [31:0] idp4,
                          input logic [31:0] instr, input logic hlt, input logic [31:0] fc);
    checkOutput({tag, ".imem_addr"},   32'(imem_addr),   addr);
    checkOutput({tag, ".id_valid"},    32'(id_valid),    32'(valid));
    checkOutput({tag, ".id_pc"},       id_pc,            idpc);
    checkOutput({tag, ".id_pc_plus4"}, id_pc_plus4,      idp4);
    checkOutput({tag, ".id_instr"},    id_instr,         instr);
    checkOutput({tag, ".halted"},      32'(halted),      32'(hlt));
    checkOutput({tag, ".fetch_count"}, fetch_count,      fc);
  endtask

  // Drive inputs away from the edge, take one rising edge, settle past it.
  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mPc = 32'h0; mHalted = 1'b0; mValid = 1'b0;
    mIdPc = 32'h0; mIdP4 = 32'h0; mInstr = NOP; mCount = 32'h0;
  endtask

  // Apply the fetch rules in priority order for one clock edge.
  task automatic modelStep(input logic s, input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    word = rom[mPc[ADDR_W+1:2]];
    if (rv) begin
      mPc = {rpc[31:2], 2'b00};
      mValid = 1'b0; mInstr = NOP; mHalted = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (mHalted) begin
      mValid = 1'b0; mInstr = NOP;
    end else begin
      mValid = 1'b1; mIdPc = mPc; mIdP4 = mPc + 32'd4; mInstr = word;
      mCount = mCount + 32'd1;
      if (word == HALT) mHalted = 1'b1;
      else mPc = mPc + 32'd4;
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < WORDS; i++) rom[i] = 32'h0000_1000 + 32'(i);
    rom[0] = 32'h0050_0513;
    rom[5] = HALT;

    //            stl   rv    rpc           addr  v     idpc          idp4          instr         hlt   fc
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        5'd1, 1'b1, 32'h00,       32'h04,       32'h0050_0513, 1'b0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        5'd2, 1'b1, 32'h04,       32'h08,       32'h0000_1001, 1'b0, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        5'd2, 1'b1, 32'h04,       32'h08,       32'h0000_1001, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        5'd2, 1'b1, 32'h04,       32'h08,       32'h0000_1001, 1'b0, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        5'd2, 1'b1, 32'h04,       32'h08,       32'h0000_1001, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        5'd3, 1'b1, 32'h08,       32'h0C,       32'h0000_1002, 1'b0, 32'd3};
    vecs[6]  = '{1'b0, 1'b1, 32'h18,       5'd6, 1'b0, 32'h08,       32'h0C,       NOP,           1'b0, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        5'd7, 1'b1, 32'h18,       32'h1C,       32'h0000_1006, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 1'b1, 32'h14,       5'd5, 1'b0, 32'h18,       32'h1C,       NOP,           1'b0, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        5'd5, 1'b1, 32'h14,       32'h18,       HALT,          1'b1, 32'd5};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        5'd5, 1'b0, 32'h14,       32'h18,       NOP,           1'b1, 32'd5};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        5'd5, 1'b0, 32'h14,       32'h18,       NOP,           1'b1, 32'd5};
    vecs[12] = '{1'b1, 1'b1, 32'h10,       5'd4, 1'b0, 32'h14,       32'h18,       NOP,           1'b0, 32'd5};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        5'd5, 1'b1, 32'h10,       32'h14,       32'h0000_1004, 1'b0, 32'd6};
    vecs[14] = '{1'b0, 1'b1, 32'h81,       5'd0, 1'b0, 32'h10,       32'h14,       NOP,           1'b0, 32'd6};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        5'd1, 1'b1, 32'h80,       32'h84,       32'h0050_0513, 1'b0, 32'd7};
    vecs[16] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 5'd31, 1'b0, 32'h80,     32'h84,       NOP,           1'b0, 32'd7};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_101F, 1'b0, 32'd8};

    // Reset values while held in reset
    #12;
    checkAll("reset", 32'd0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].stl, vecs[i].rv, vecs[i].rpc);
      checkAll($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].idpc,
               vecs[i].idp4, vecs[i].instr, vecs[i].hlt, vecs[i].fc);
    end

    // Async reset pulse mid-cycle: outputs must clear before any edge
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 32'd0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // Randomized traffic against the model, with a fresh random ROM
    for (int i = 0; i < WORDS; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
    for (int n = 0; n < 3000; n++) begin
      logic        s, rv;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      modelStep(s, rv, rpc);
      applyStimulus(s, rv, rpc);
      checkAll($sformatf("rand%0d", n), 32'(mPc[ADDR_W+1:2]), mValid, mIdPc, mIdP4,
               mInstr, mHalted, mCount);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
